// File: rtl/jpeg_entropy_bit_reader.sv
// JPEG scan bit reader: strips 0xFF00 stuffing, halts on markers and presents an
// MSB-first bit window that the Huffman decoder consumes a variable number of bits from.
module jpeg_entropy_bit_reader #(
    parameter int BUF_W = 32,
    parameter int WIN_W = 16,
    localparam int CL_W   = $clog2(WIN_W + 1),
    localparam int FILL_W = $clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              cons_valid,
    input  logic [CL_W-1:0]   cons_len,
    output logic [WIN_W-1:0]  win,
    output logic [FILL_W-1:0] fill,
    output logic              marker_valid,
    output logic [7:0]        marker_code,
    input  logic              marker_ack,
    input  logic              flush,
    output logic              err_underflow
);

    typedef enum logic [1:0] {ST_NORMAL, ST_GOT_FF, ST_MARKER} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    bits_q, bits_d, shifted;
    logic [FILL_W-1:0]   fill_q, fill_d, fill_mid;
    logic                mv_q, mv_d;
    logic [7:0]          code_q, code_d;
    logic                err_q, err_d;
    logic                accept, append, cons_ok, underflow;
    logic [7:0]          app_byte;

    // Handshakes: a byte transfers on a cycle where in_valid && in_ready; in_ready
    // depends only on registered state/fill (and is held low during reset).
    assign in_ready = !rst && (state_q != ST_MARKER) && (fill_q <= FILL_W'(BUF_W - 8));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        mv_d     = mv_q;
        code_d   = code_q;
        append   = 1'b0;
        app_byte = in_data;
        case (state_q)
            ST_NORMAL: begin
                if (accept) begin
                    if (in_data == 8'hFF) state_d = ST_GOT_FF;
                    else                  append  = 1'b1;
                end
            end
            ST_GOT_FF: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        append   = 1'b1;
                        app_byte = 8'hFF;
                        state_d  = ST_NORMAL;
                    end else if (in_data != 8'hFF) begin
                        code_d  = in_data;
                        mv_d    = 1'b1;
                        state_d = ST_MARKER;
                    end
                end
            end
            ST_MARKER: begin
                if (marker_ack) begin
                    mv_d    = 1'b0;
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase

        // Consume first, then the new byte lands directly below what remains.
        cons_ok   = cons_valid && (FILL_W'(cons_len) <= fill_q);
        underflow = cons_valid && (FILL_W'(cons_len) > fill_q);
        shifted   = cons_ok ? (bits_q << cons_len) : bits_q;
        fill_mid  = cons_ok ? (fill_q - FILL_W'(cons_len)) : fill_q;
        bits_d    = shifted | (append ? ({app_byte, {(BUF_W-8){1'b0}}} >> fill_mid) : '0);
        fill_d    = fill_mid + (append ? FILL_W'(8) : '0);
        err_d     = err_q | underflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            bits_q  <= '0;
            fill_q  <= '0;
            mv_q    <= 1'b0;
            code_q  <= 8'h00;
            err_q   <= 1'b0;
        end else if (flush) begin
            // marker_code is deliberately kept across a flush
            state_q <= ST_NORMAL;
            bits_q  <= '0;
            fill_q  <= '0;
            mv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            fill_q  <= fill_d;
            mv_q    <= mv_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign win           = bits_q[BUF_W-1 -: WIN_W];
    assign fill          = fill_q;
    assign marker_valid  = mv_q;
    assign marker_code   = code_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_jpeg_entropy_bit_reader.sv
// Bench for jpeg_entropy_bit_reader: directed cases plus random traffic checked
// against a bit-queue reference model through an expected-value scoreboard.
module tb_jpeg_entropy_bit_reader;
    localparam int BUF_W = 32;
    localparam int WIN_W = 16;
    localparam int EXP_W = 6 + 16 + 1 + 8 + 1 + 1;

    logic        clk = 0;
    logic        rst;
    logic        in_valid, cons_valid, marker_ack, flush;
    logic [7:0]  in_data;
    logic [4:0]  cons_len;
    logic        in_ready, marker_valid, err_underflow;
    logic [15:0] win;
    logic [5:0]  fill;
    logic [7:0]  marker_code;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    // reference model state
    bit        mq[$];
    bit        m_pend, m_halt, m_mv, m_err;
    bit [7:0]  m_code;

    jpeg_entropy_bit_reader #(.BUF_W(BUF_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cons_valid(cons_valid), .cons_len(cons_len), .win(win), .fill(fill),
        .marker_valid(marker_valid), .marker_code(marker_code), .marker_ack(marker_ack),
        .flush(flush), .err_underflow(err_underflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_pend = 0; m_halt = 0; m_mv = 0; m_err = 0; m_code = 8'h00;
    endfunction

    function automatic bit model_ready();
        return !m_halt && (mq.size() <= BUF_W - 8);
    endfunction

    function automatic void push_byte(input bit [7:0] b);
        for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
    endfunction

    function automatic void model_step(input bit iv, input bit [7:0] id, input bit cv,
                                       input int cl, input bit ma, input bit fl);
        bit acc, was_halt;
        if (fl) begin
            mq.delete();
            m_pend = 0; m_halt = 0; m_mv = 0; m_err = 0;
            return;
        end
        acc = iv && model_ready();
        was_halt = m_halt;
        if (cv) begin
            if (cl <= mq.size()) repeat (cl) void'(mq.pop_front());
            else m_err = 1;
        end
        if (acc) begin
            if (!m_pend) begin
                if (id == 8'hFF) m_pend = 1;
                else push_byte(id);
            end else if (id == 8'h00) begin
                push_byte(8'hFF);
                m_pend = 0;
            end else if (id != 8'hFF) begin
                m_code = id; m_mv = 1; m_halt = 1; m_pend = 0;
            end
        end
        if (was_halt && ma) begin
            m_halt = 0; m_mv = 0;
        end
    endfunction

    function automatic logic [EXP_W-1:0] model_vec();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < WIN_W; i++) if (i < mq.size()) w[WIN_W-1-i] = mq[i];
        return {6'(mq.size()), w, m_mv, m_code, m_err, model_ready()};
    endfunction

    // driver: called at a negedge, drives one cycle and queues the expected result
    task automatic step(input logic iv, input logic [7:0] id, input logic cv,
                        input logic [4:0] cl, input logic ma, input logic fl);
        in_valid = iv; in_data = id; cons_valid = cv; cons_len = cl;
        marker_ack = ma; flush = fl;
        model_step(iv, id, cv, int'(cl), ma, fl);
        exp_q.push_back(model_vec());
        @(negedge clk);
        in_valid = 0; cons_valid = 0; marker_ack = 0; flush = 0;
    endtask

    task automatic byte_in(input logic [7:0] b); step(1, b, 0, 0, 0, 0); endtask
    task automatic cons(input logic [4:0] n);    step(0, 8'h00, 1, n, 0, 0); endtask
    task automatic do_flush();                   step(0, 8'h00, 0, 0, 0, 1); endtask

    // monitor: compare every post-edge output against the scoreboard
    always @(posedge clk) begin
        logic [EXP_W-1:0] e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", {fill, win, marker_valid, marker_code, err_underflow, in_ready}, e);
        end
    end

    initial begin
        rst = 1; in_valid = 0; in_data = 0; cons_valid = 0; cons_len = 0;
        marker_ack = 0; flush = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_fill", fill, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_marker", {marker_valid, marker_code, err_underflow}, 0);
        rst = 0;
        @(negedge clk);

        byte_in(8'h12); byte_in(8'h34);
        chk("t1_fill", fill, 16); chk("t1_win", win, 16'h1234);
        cons(4);
        chk("t1_cons_fill", fill, 12); chk("t1_cons_win", win, 16'h2340);

        do_flush();
        byte_in(8'hFF); byte_in(8'h00); byte_in(8'hAB);
        chk("stuff_fill", fill, 16); chk("stuff_win", win, 16'hFFAB);
        chk("stuff_nomarker", marker_valid, 0);

        do_flush();
        byte_in(8'hFF); byte_in(8'hFF); byte_in(8'hD9);
        chk("mk_valid", marker_valid, 1); chk("mk_code", marker_code, 8'hD9);
        chk("mk_ready", in_ready, 0); chk("mk_fill", fill, 0);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("ack_valid", marker_valid, 0); chk("ack_ready", in_ready, 1);

        do_flush();
        byte_in(8'hA5); byte_in(8'h5A); byte_in(8'hC3);
        chk("full_ready24", in_ready, 1);
        step(1, 8'h7E, 1, 5, 0, 0);
        chk("sim_fill", fill, 27); chk("sim_win", win, 16'hAB58);
        chk("sim_ready", in_ready, 0);

        do_flush();
        byte_in(8'h12); cons(5);
        chk("uf_pre_fill", fill, 3);
        cons(7);
        chk("uf_err", err_underflow, 1); chk("uf_fill", fill, 3);
        do_flush();
        chk("uf_clr_err", err_underflow, 0); chk("uf_clr_fill", fill, 0);

        byte_in(8'h11); byte_in(8'hFF); byte_in(8'hD0);
        chk("rm_marker", {marker_valid, fill}, {1'b1, 6'd8});
        rst = 1;
        #1;
        chk("rm_fill", fill, 0); chk("rm_win", win, 0);
        chk("rm_flags", {marker_valid, marker_code, err_underflow, in_ready}, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        byte_in(8'h55);
        chk("rm_after_fill", fill, 8); chk("rm_after_win", win, 16'h5500);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hFF;
            else if (r == 2) b = 8'h00;
            else             b = 8'($urandom);
            step(($urandom % 4) != 0, b, ($urandom % 2) == 0, 5'($urandom_range(0, 16)),
                 ($urandom % 3) == 0, ($urandom % 50) == 0);
        end

        @(negedge clk);
        chk("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jpeg_entropy_bit_reader.md
Name: jpeg_entropy_bit_reader

Overview:
- Decode-side counterpart of the entropy-coded segment writer: accepts the JPEG scan byte stream and removes byte stuffing (0xFF 0x00 becomes data 0xFF).
- Detects and halts on markers.
- Presents an MSB-first bit window to the Huffman decoder, which consumes a variable number of bits per cycle.
- Sits between the byte-level input FIFO and the Huffman/run-length decode pipeline.

Parameters:
- BUF_W, 32, bit-buffer depth in bits; must be a multiple of 8 and at least 24.
- WIN_W, 16, peek window width in bits; at most BUF_W-8. Also the maximum consume length.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input byte valid.
- in_data  input  8  scan byte.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- cons_valid  input  1  consume request.
- cons_len  input  $clog2(WIN_W+1)  bits to consume, 0..WIN_W.
- win  output  WIN_W  next WIN_W bits MSB-first. Bits beyond fill read 0.
- fill  output  $clog2(BUF_W+1)  number of valid bits buffered.
- marker_valid  output  1  marker detected; stream halted.
- marker_code  output  8  second byte of the marker.
- marker_ack  input  1  releases the halt.
- flush  input  1  synchronous clear of the buffer and state.
- err_underflow  output  1  sticky; set when a consume exceeds fill.

Behaviour:
- Reset (asynchronous, immediate): fill=0, buffer=0, state=NORMAL, in_ready=0 while rst high, marker_valid=0, marker_code=0x00, err_underflow=0.
- States: NORMAL, GOT_FF, MARKER.
- in_ready = (state!=MARKER) && (fill <= BUF_W-8). It is registered-state based and combinational from fill/state only, never from in_valid.
- NORMAL:
  - Byte != 0xFF: append 8 bits below the current valid bits.
  - Byte == 0xFF: append nothing; go to GOT_FF.
- GOT_FF:
  - 0x00: append 0xFF; go to NORMAL.
  - 0xFF: discard (fill byte); stay in GOT_FF.
  - Any other byte: marker_code <= byte, marker_valid <= 1, go to MARKER.
- MARKER:
  - in_ready=0.
  - Consumes of already-buffered bits remain legal.
  - marker_ack (only meaningful in MARKER): next cycle marker_valid=0, state=NORMAL. marker_code holds its value.
- Consume:
  - When cons_valid && cons_len <= fill: the top cons_len bits are removed and the rest shift toward the MSB.
  - When cons_len > fill: the buffer is unchanged and err_underflow <= 1. It clears only on rst or flush.
  - cons_len=0 is a no-op.
- Simultaneous append and consume in the same cycle: new fill = fill - cons_len + appended bits (0 or 8).
  - The appended byte lands immediately below the remaining bits.
  - In-range values never exceed BUF_W because in_ready requires fill <= BUF_W-8.
- Latency: an accepted byte or a consume is reflected in win/fill on the next clock edge. win is a registered/shift function of the buffer with no combinational path from in_data.
- flush: next cycle fill=0, buffer=0, state=NORMAL, marker_valid=0, err_underflow=0.
  - A byte or consume presented in the same cycle is dropped.
  - flush has priority over marker_ack.
- Reset asserted mid-marker or mid-GOT_FF returns to the reset state. A pending 0xFF is lost.

Test Plan:
- Bytes 0x12, 0x34 then peek -> fill=16, win=0x1234. Consume 4 -> fill=12, win=0x2340.
- Bytes 0xFF, 0x00, 0xAB -> fill=16, win=0xFFAB. No marker raised.
- Bytes 0xFF, 0xFF, 0xD9 with fill=0 -> marker_valid=1, marker_code=0xD9, in_ready=0, fill=0. marker_ack -> marker_valid=0 next cycle, in_ready=1.
- fill=24 (0xA5,0x5A,0xC3), same cycle byte 0x7E plus consume 5:
  - Result: fill=27.
  - Buffer bits = 0xA55AC3 shifted left 5, followed by 0x7E.
  - win=0xAB58.
  - in_ready=0 at fill=27 (>24).
- fill=3, consume 7 -> err_underflow=1, fill stays 3. flush -> err_underflow=0, fill=0.
- Assert rst while in MARKER with fill=8 -> all outputs at reset values immediately. Byte 0x55 after release -> fill=8, win=0x5500.
